seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit 7-segment display.
- Holds a latched hex word and drives one shared hex-to-segment decoder across NUM_DIGITS digits, one digit at a time.
- Inserts a dead-time gap between digits to suppress ghosting.
- Sits between the CPU debug/IO register (PC, register or ALU value) and the board anode/segment pins.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_hex_decode.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: glyph table and FSM state encodings.
package seg_pkg;

    // Glyph bit order is a..g from MSB to LSB.
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to a..g glyph lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_0;
        case (nib)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-slot dead time.
// Optional leading-zero suppression is enabled by defining SEG_LZ_SUPPRESS_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_COUNT   = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [7:0]              seg_out,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] data_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        dead_reg;
    scan_state_t             state_reg;
    logic [3:0]              cur_nib_reg;
    logic                    cur_dp_reg;
    logic                    cur_dark_reg;

    logic [IDX_W+1:0]        nib_base;
    logic [3:0]              nib_sel;
    logic [3:0]              dec_nib;
    logic [6:0]              glyph;
    logic                    dp_sel;
    logic                    lz_dark;
    logic [NUM_DIGITS-1:0]   an_sel;

    assign nib_base = {idx_reg, 2'b00};
    assign nib_sel  = data_reg[nib_base +: 4];
    assign dp_sel   = dp_reg[idx_reg];

    // The single decoder sees the about-to-be-latched nibble while blank, the held one while driving.
    assign dec_nib = (state_reg == ST_BLANK) ? nib_sel : cur_nib_reg;

    seg_hex_decode u_dec (
        .nib   (dec_nib),
        .glyph (glyph)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
        assign an_sel[gi] = (idx_reg != IDX_W'(gi));
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic [NUM_DIGITS:0] zero_from;
    assign zero_from[NUM_DIGITS] = 1'b1;
    // zero_from[k] is set when nibbles k..NUM_DIGITS-1 are all zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign zero_from[gi] = (data_reg[4*gi +: 4] == 4'h0) && zero_from[gi+1];
    end
    assign lz_dark = (idx_reg != '0) && zero_from[idx_reg];
`else
    assign lz_dark = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg     <= '0;
            dp_reg       <= '0;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            dead_reg     <= '0;
            state_reg    <= ST_BLANK;
            cur_nib_reg  <= '0;
            cur_dp_reg   <= 1'b0;
            cur_dark_reg <= 1'b0;
            an_out       <= '1;
            seg_out      <= SEG_BLANK;
            frame_tick   <= 1'b0;
        end else begin
            if (load) begin
                data_reg <= data_in;
                dp_reg   <= dp_in;
            end
            frame_tick <= 1'b0;

            if (!en) begin
                // Pausing drops back to BLANK so the dead time is re-run on resume.
                an_out    <= '1;
                seg_out   <= SEG_BLANK;
                state_reg <= ST_BLANK;
                dead_reg  <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg    <= '0;
                dead_reg   <= '0;
                idx_reg    <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                frame_tick <= (idx_reg == IDX_LAST);
                state_reg  <= ST_BLANK;
                an_out     <= '1;
                seg_out    <= SEG_BLANK;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                case (state_reg)
                    ST_BLANK: begin
                        if (dead_reg == DEAD_LAST) begin
                            state_reg    <= ST_DRIVE;
                            cur_nib_reg  <= nib_sel;
                            cur_dp_reg   <= dp_sel;
                            cur_dark_reg <= lz_dark;
                            an_out       <= (blank_mask[idx_reg] || lz_dark) ? '1 : an_sel;
                            seg_out      <= {glyph, dp_sel};
                        end else begin
                            dead_reg <= dead_reg + 1'b1;
                            an_out   <= '1;
                            seg_out  <= SEG_BLANK;
                        end
                    end
                    default: begin
                        an_out  <= (blank_mask[idx_reg] || cur_dark_reg) ? '1 : an_sel;
                        seg_out <= {glyph, cur_dp_reg};
                    end
                endcase
            end
        end
    end

endmodule
